sched_task_fifo: RTL and testbench
==================================

// Module: sched_task_fifo
// PURPOSE
//  Parametrised task-ID queue for the PLC CPU scheduler, successor to the fixed 12x32 scheduler queue.
//  Buffers task/job words between the interrupt/timer front end and the dispatcher.
//  Adds: configurable depth, concurrent read+write, FULL/AFULL/LEVEL status, output-valid strobe.
//  Single clock domain; sits between the scheduler request logic and the instruction fetch dispatcher.
// PARAMETERS
//  D_W     12  data word width (task ID + priority bits)
//  DEPTH   32  number of entries; power of two, >= 2
//  AF_THR  28  AFULL asserts when LEVEL >= AF_THR; 1..DEPTH
//  A_W     derived localparam = clog2(DEPTH); pointer width (not overridable)
// PORTS
//  CLK     in   1        system clock, rising-edge
//  CLR     in   1        reset, asynchronous, active-high
//  EN      in   1        operation enable; 0 = no read/write accepted
//  WR      in   1        write request
//  RD      in   1        read request
//  D_IN    in   D_W      write data
//  D_OUT   out  D_W      read data, registered
//  D_VALID out  1        1-cycle strobe: D_OUT updated by a read accepted on previous edge
//  EMPTY   out  1        LEVEL == 0
//  FULL    out  1        LEVEL == DEPTH
//  AFULL   out  1        LEVEL >= AF_THR
//  LEVEL   out  A_W+1    current occupancy, 0..DEPTH
//  OVF     out  1        (SCHED_FIFO_ERR_EN only) sticky: write attempted while FULL and not accepted
//  UDF     out  1        (SCHED_FIFO_ERR_EN only) sticky: read attempted while EMPTY
// BEHAVIOUR
//  - Reset (CLR=1, async): rd_ptr=wr_ptr=0, LEVEL=0, D_OUT=0, D_VALID=0, EMPTY=1, FULL=0, AFULL=0, OVF=UDF=0.
//    Memory contents not cleared. Reset mid-operation discards all queued entries immediately.
//  - Accept rules (sampled at posedge, EN=1 only):
//      rd_ok = RD & ~EMPTY;  wr_ok = WR & (~FULL | rd_ok)
//  - Read latency 1: on rd_ok, D_OUT <= mem[rd_ptr], D_VALID=1 next cycle; else D_VALID=0, D_OUT holds.
//  - Write: on wr_ok, mem[wr_ptr] <= D_IN.
//  - Simultaneous RD+WR: both accepted when not EMPTY, LEVEL unchanged. When EMPTY only write accepted
//    (no bypass; written word readable from the next cycle). When FULL with RD+WR: both accepted.
//  - Pointers A_W bits, wrap modulo DEPTH naturally (DEPTH power of two).
//  - LEVEL <= LEVEL + wr_ok - rd_ok; never exceeds DEPTH nor underflows. Flags derived combinationally from LEVEL.
//  - EN=0: no pointer/LEVEL/memory change, D_VALID=0, D_OUT holds; RD/WR ignored (no error flags set).
//  - Elaboration error ($error / invalid generate) if DEPTH not power of two or AF_THR outside 1..DEPTH.
// CONFIGURATION
//  SCHED_FIFO_ERR_EN defined: OVF/UDF ports present; OVF sets when EN&WR&FULL&~RD, UDF when EN&RD&EMPTY;
//    both sticky until CLR. Rejected operations themselves unchanged.
//  Undefined: OVF/UDF ports and logic absent; rejected requests silently dropped.
// STRUCTURE
//  - Shared include sched_pkg.vh: `define SCHED_TASK_W 12, `define SCHED_Q_DEPTH 32, clog2 constant function.
//  - Sub-module sched_fifo_mem: simple dual-port RAM, D_W x DEPTH, sync write, registered read port with
//    read-enable (maps to block/distributed RAM). Top holds pointers, LEVEL, flags, error logic.
// TESTING
//  1 Reset: pulse CLR mid-clock -> all outputs at reset values before next edge; LEVEL=0, EMPTY=1.
//  2 Fill: 32 writes 0x001..0x020 -> AFULL at LEVEL=28, FULL at 32; 33rd write dropped, LEVEL=32 (OVF=1 with macro).
//  3 Drain: 32 reads -> D_OUT 0x001..0x020 in order, D_VALID one cycle after each RD; then RD -> D_VALID=0 (UDF=1 with macro).
//  4 Concurrent: LEVEL=5, RD+WR for 40 cycles -> LEVEL stays 5, pointers wrap, data order preserved.
//  5 Boundaries: EMPTY with RD+WR -> LEVEL 0->1, D_VALID=0; FULL with RD+WR -> LEVEL stays 32, both accepted.
//  6 EN=0 with RD=WR=1 for 10 cycles -> no change in LEVEL, D_OUT, flags; DEPTH=4,D_W=8 rerun of 2-3.

Source files
------------

// File: rtl/sched_task_fifo_pkg.sv
// Shared constants and helpers for the scheduler task queue.
// Provides the default task-word width, queue depth and a constant clog2.
package sched_task_fifo_pkg;

  localparam int unsigned SchedTaskW  = 12;
  localparam int unsigned SchedQDepth = 32;

  // Usable in parameter lists; returns 1 for n <= 2 so the pointers are never zero-width.
  function automatic int unsigned sched_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sched_task_fifo_mem.sv
// Simple dual-port storage for the task queue.
// Synchronous write, registered read port with read enable; the output register clears on CLR.
module sched_task_fifo_mem #(
  parameter int unsigned D_W   = 12,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned A_W   = 5
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  logic [D_W-1:0] wdata,
  input  logic           re,
  input  logic [A_W-1:0] raddr,
  output logic [D_W-1:0] rdata
);

  logic [D_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sched_task_fifo.sv
// Parametrised task-ID queue between scheduler request logic and the dispatcher.
// Define SCHED_FIFO_ERR_EN to add the sticky OVF/UDF error flags.
module sched_task_fifo
  import sched_task_fifo_pkg::*;
#(
  parameter  int unsigned D_W    = SchedTaskW,
  parameter  int unsigned DEPTH  = SchedQDepth,
  parameter  int unsigned AF_THR = 28,
  localparam int unsigned A_W    = sched_clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           EN,
  input  logic           WR,
  input  logic           RD,
  input  logic [D_W-1:0] D_IN,
  output logic [D_W-1:0] D_OUT,
  output logic           D_VALID,
  output logic           EMPTY,
  output logic           FULL,
  output logic           AFULL,
`ifdef SCHED_FIFO_ERR_EN
  output logic           OVF,
  output logic           UDF,
`endif
  output logic [A_W:0]   LEVEL
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sched_task_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_THR < 1) || (AF_THR > DEPTH)) begin : g_bad_af_thr
    $error("sched_task_fifo: AF_THR must lie in 1..DEPTH");
  end

  logic [A_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [A_W:0]   level_q, level_d;
  logic           d_valid_q;
  logic           rd_ok, wr_ok;

  assign EMPTY = (level_q == '0);
  assign FULL  = (level_q == (A_W + 1)'(DEPTH));
  assign AFULL = (level_q >= (A_W + 1)'(AF_THR));
  assign LEVEL = level_q;
  assign D_VALID = d_valid_q;

  // A full queue still takes a write when a read frees a slot on the same edge.
  assign rd_ok = EN & RD & ~EMPTY;
  assign wr_ok = EN & WR & (~FULL | rd_ok);

  always_comb begin
    level_d = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (A_W + 1)'(1);
      2'b01:   level_d = level_q - (A_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      d_valid_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      d_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + A_W'(1);
      end
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + A_W'(1);
      end
    end
  end

  sched_task_fifo_mem #(
    .D_W  (D_W),
    .DEPTH(DEPTH),
    .A_W  (A_W)
  ) u_mem (
    .CLK  (CLK),
    .CLR  (CLR),
    .we   (wr_ok),
    .waddr(wr_ptr_q),
    .wdata(D_IN),
    .re   (rd_ok),
    .raddr(rd_ptr_q),
    .rdata(D_OUT)
  );

`ifdef SCHED_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (EN & WR & FULL & ~RD) begin
        ovf_q <= 1'b1;
      end
      if (EN & RD & EMPTY) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_sched_task_fifo.sv
// Directed bench for sched_task_fifo: default 32x12 instance plus a 4x8 instance.
// Honours SCHED_FIFO_ERR_EN when the RTL is built with it.
module tb_sched_task_fifo;

  logic        CLK;
  logic        CLR;
  logic        EN, WR, RD;
  logic [11:0] D_IN, D_OUT;
  logic        D_VALID, EMPTY, FULL, AFULL;
  logic [5:0]  LEVEL;
`ifdef SCHED_FIFO_ERR_EN
  logic        OVF, UDF;
`endif

  logic        s_en, s_wr, s_rd;
  logic [7:0]  s_din, s_dout;
  logic        s_valid, s_empty, s_full, s_afull;
  logic [2:0]  s_level;
`ifdef SCHED_FIFO_ERR_EN
  logic        s_ovf, s_udf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] model_q[$];
  logic [11:0] exp_dout;
  logic        exp_ovf, exp_udf;

  sched_task_fifo dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .EN     (EN),
    .WR     (WR),
    .RD     (RD),
    .D_IN   (D_IN),
    .D_OUT  (D_OUT),
    .D_VALID(D_VALID),
    .EMPTY  (EMPTY),
    .FULL   (FULL),
    .AFULL  (AFULL),
`ifdef SCHED_FIFO_ERR_EN
    .OVF    (OVF),
    .UDF    (UDF),
`endif
    .LEVEL  (LEVEL)
  );

  sched_task_fifo #(
    .D_W   (8),
    .DEPTH (4),
    .AF_THR(3)
  ) dut_small (
    .CLK    (CLK),
    .CLR    (CLR),
    .EN     (s_en),
    .WR     (s_wr),
    .RD     (s_rd),
    .D_IN   (s_din),
    .D_OUT  (s_dout),
    .D_VALID(s_valid),
    .EMPTY  (s_empty),
    .FULL   (s_full),
    .AFULL  (s_afull),
`ifdef SCHED_FIFO_ERR_EN
    .OVF    (s_ovf),
    .UDF    (s_udf),
`endif
    .LEVEL  (s_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // One cycle on the 32-deep instance, checked against a queue model.
  task automatic op(input logic en, input logic wr, input logic rd, input logic [11:0] din);
    logic r_ok, w_ok;
    EN = en; WR = wr; RD = rd; D_IN = din;
    r_ok = en && rd && (model_q.size() > 0);
    w_ok = en && wr && ((model_q.size() < 32) || r_ok);
    if (en && wr && (model_q.size() == 32) && !rd) exp_ovf = 1'b1;
    if (en && rd && (model_q.size() == 0)) exp_udf = 1'b1;
    if (r_ok) exp_dout = model_q.pop_front();
    if (w_ok) model_q.push_back(din);
    cyc();
    check("level", 32'(LEVEL), model_q.size());
    check("d_valid", 32'(D_VALID), 32'(r_ok));
    check("d_out", 32'(D_OUT), 32'(exp_dout));
    check("empty", 32'(EMPTY), 32'(model_q.size() == 0));
    check("full", 32'(FULL), 32'(model_q.size() == 32));
    check("afull", 32'(AFULL), 32'(model_q.size() >= 28));
`ifdef SCHED_FIFO_ERR_EN
    check("ovf", 32'(OVF), 32'(exp_ovf));
    check("udf", 32'(UDF), 32'(exp_udf));
`endif
    EN = 1'b1; WR = 1'b0; RD = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(LEVEL), 0);
    check({tag, "_empty"}, 32'(EMPTY), 1);
    check({tag, "_full"}, 32'(FULL), 0);
    check({tag, "_afull"}, 32'(AFULL), 0);
    check({tag, "_dvalid"}, 32'(D_VALID), 0);
    check({tag, "_dout"}, 32'(D_OUT), 0);
`ifdef SCHED_FIFO_ERR_EN
    check({tag, "_ovf"}, 32'(OVF), 0);
    check({tag, "_udf"}, 32'(UDF), 0);
`endif
  endtask

  initial begin
    CLR = 1'b1; EN = 1'b1; WR = 1'b0; RD = 1'b0; D_IN = '0;
    s_en = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_din = '0;
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    #12;
    check_reset_outputs("rst");
    CLR = 1'b0;

    // EN=0 on an empty queue: nothing accepted, no error flags.
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, 1'b1, 12'h555);

    // Fill with 0x001..0x020, watching the thresholds.
    for (int i = 1; i <= 32; i++) begin
      op(1'b1, 1'b1, 1'b0, 12'(i));
      check("fill_afull", 32'(AFULL), 32'(i >= 28));
      check("fill_full", 32'(FULL), 32'(i == 32));
    end
    op(1'b1, 1'b1, 1'b0, 12'h3FF);
    check("ovf_level", 32'(LEVEL), 32);

    // Drain in order.
    for (int i = 1; i <= 32; i++) begin
      op(1'b1, 1'b0, 1'b1, 12'h000);
      check("drain_data", 32'(D_OUT), i);
      check("drain_valid", 32'(D_VALID), 1);
    end
    op(1'b1, 1'b0, 1'b1, 12'h000);
    check("udf_valid", 32'(D_VALID), 0);
    check("udf_hold", 32'(D_OUT), 32'h020);

    // Concurrent traffic at LEVEL=5 long enough for both pointers to wrap.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b1, 1'b0, 12'h100 + 12'(i));
    for (int k = 0; k < 40; k++) begin
      op(1'b1, 1'b1, 1'b1, 12'h200 + 12'(k));
      check("conc_level", 32'(LEVEL), 5);
    end
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b1, 12'h000);
    check("conc_last", 32'(D_OUT), 32'h227);

    // Empty with RD+WR: only the write lands, no bypass.
    op(1'b1, 1'b1, 1'b1, 12'hABC);
    check("empty_rw_level", 32'(LEVEL), 1);
    check("empty_rw_valid", 32'(D_VALID), 0);
    op(1'b1, 1'b0, 1'b1, 12'h000);
    check("empty_rw_data", 32'(D_OUT), 32'hABC);

    // Full with RD+WR: both accepted.
    for (int i = 0; i < 32; i++) op(1'b1, 1'b1, 1'b0, 12'h300 + 12'(i));
    op(1'b1, 1'b1, 1'b1, 12'h7AA);
    check("full_rw_level", 32'(LEVEL), 32);
    check("full_rw_data", 32'(D_OUT), 32'h300);

    // EN=0 while full: state frozen.
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, 1'b1, 12'h0F0);
    check("en0_dout", 32'(D_OUT), 32'h300);

    // Asynchronous reset between edges.
    #1 CLR = 1'b1;
    #2;
    check_reset_outputs("midclr");
    #1 CLR = 1'b0;
    model_q.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    op(1'b1, 1'b1, 1'b0, 12'h0C3);
    op(1'b1, 1'b0, 1'b1, 12'h000);
    check("post_clr_data", 32'(D_OUT), 32'h0C3);

    // Small DEPTH=4, D_W=8 instance: fill and drain.
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1; s_din = 8'hA1 + 8'(i);
      cyc();
      check("s_fill_level", 32'(s_level), i + 1);
      check("s_fill_afull", 32'(s_afull), 32'(i + 1 >= 3));
      check("s_fill_full", 32'(s_full), 32'(i + 1 == 4));
    end
    s_din = 8'hEE;
    cyc();
    check("s_ovf_level", 32'(s_level), 4);
`ifdef SCHED_FIFO_ERR_EN
    check("s_ovf", 32'(s_ovf), 1);
`endif
    s_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rd = 1'b1;
      cyc();
      check("s_drain_data", 32'(s_dout), 32'(8'hA1 + 8'(i)));
      check("s_drain_valid", 32'(s_valid), 1);
      check("s_drain_level", 32'(s_level), 3 - i);
    end
    cyc();
    check("s_udf_valid", 32'(s_valid), 0);
    check("s_udf_hold", 32'(s_dout), 32'hA4);
    check("s_empty", 32'(s_empty), 1);
`ifdef SCHED_FIFO_ERR_EN
    check("s_udf", 32'(s_udf), 1);
`endif
    s_rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
